// File: rtl/backdoor_mem_arbiter.sv
// Round-robin backdoor access engine. Each channel has a request FIFO, and one
// request at a time is issued to the shared memory port. Read data returns to the requesting channel.
module backdoor_mem_arbiter #(
    parameter int NUM_CH     = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            req_valid,
    output logic [NUM_CH-1:0]            req_ready,
    input  logic [NUM_CH-1:0]            req_write,
    input  logic [NUM_CH*ADDR_W-1:0]     req_addr,
    input  logic [NUM_CH*DATA_W-1:0]     req_wdata,
    input  logic [NUM_CH*(DATA_W/8)-1:0] req_mask,
    output logic [NUM_CH-1:0]            rsp_valid,
    output logic [DATA_W-1:0]            rsp_rdata,
    input  logic                         mem_busy,
    output logic                         mem_req,
    output logic                         mem_write,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    output logic [DATA_W/8-1:0]          mem_mask,
    input  logic [DATA_W-1:0]            mem_rdata,
    output logic [1:0]                   dbg_state
);
    localparam int MASK_W = DATA_W / 8;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int PW     = AW + 1;
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2} state_e;

    // Handshake: a request on channel c is accepted on a clock edge where
    // req_valid[c] and req_ready[c] are both high; req_ready depends only on
    // registered FIFO pointers, so a pop never makes room in the same cycle.

    logic              fifo_wr_q   [NUM_CH][FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_addr_q [NUM_CH][FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [NUM_CH][FIFO_DEPTH];
    logic [MASK_W-1:0] fifo_mask_q [NUM_CH][FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q    [NUM_CH];
    logic [PW-1:0]     rd_ptr_q    [NUM_CH];

    logic [NUM_CH-1:0] full, empty, push, pop_vec;
    logic              found;

    state_e            state_q, state_d;
    logic [CH_W-1:0]   grant_q, grant_d, rr_q, rr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0] rsp_valid_q, rsp_d;
    logic [DATA_W-1:0] rsp_rdata_q, rdata_d;
    logic              ent_wr_q;
    logic [ADDR_W-1:0] ent_addr_q;
    logic [DATA_W-1:0] ent_data_q;
    logic [MASK_W-1:0] ent_mask_q;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            empty[c] = (wr_ptr_q[c] == rd_ptr_q[c]);
            full[c]  = (wr_ptr_q[c][PW-1] != rd_ptr_q[c][PW-1]) &&
                       (wr_ptr_q[c][AW-1:0] == rd_ptr_q[c][AW-1:0]);
            push[c]  = req_valid[c] && !full[c];
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        rsp_d   = '0;
        rdata_d = rsp_rdata_q;
        pop_vec = '0;
        found   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!mem_busy) begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (!found && !empty[(int'(rr_q) + i) % NUM_CH]) begin
                            found   = 1'b1;
                            grant_d = CH_W'((int'(rr_q) + i) % NUM_CH);
                        end
                    end
                end
                if (found) begin
                    pop_vec[grant_d] = 1'b1;
                    rr_d             = (int'(grant_d) == NUM_CH - 1) ? '0 : grant_d + 1'b1;
                    state_d          = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (ent_wr_q) begin
                    rsp_d[grant_q] = 1'b1;
                    state_d        = S_IDLE;
                end else begin
                    cnt_d   = CNT_W'(RD_LATENCY - 1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    rsp_d[grant_q] = 1'b1;
                    rdata_d        = mem_rdata;
                    state_d        = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            rr_q        <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            ent_wr_q    <= 1'b0;
            ent_addr_q  <= '0;
            ent_data_q  <= '0;
            ent_mask_q  <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
            end
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_d;
            rsp_rdata_q <= rdata_d;
            if (found) begin
                ent_wr_q   <= fifo_wr_q[grant_d][rd_ptr_q[grant_d][AW-1:0]];
                ent_addr_q <= fifo_addr_q[grant_d][rd_ptr_q[grant_d][AW-1:0]];
                ent_data_q <= fifo_data_q[grant_d][rd_ptr_q[grant_d][AW-1:0]];
                ent_mask_q <= fifo_mask_q[grant_d][rd_ptr_q[grant_d][AW-1:0]];
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (push[c])    wr_ptr_q[c] <= wr_ptr_q[c] + 1'b1;
                if (pop_vec[c]) rd_ptr_q[c] <= rd_ptr_q[c] + 1'b1;
            end
        end
    end

    // Payload storage needs no reset; only the pointers define valid entries.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (push[c]) begin
                fifo_wr_q[c][wr_ptr_q[c][AW-1:0]]   <= req_write[c];
                fifo_addr_q[c][wr_ptr_q[c][AW-1:0]] <= req_addr[c*ADDR_W +: ADDR_W];
                fifo_data_q[c][wr_ptr_q[c][AW-1:0]] <= req_wdata[c*DATA_W +: DATA_W];
                fifo_mask_q[c][wr_ptr_q[c][AW-1:0]] <= req_mask[c*MASK_W +: MASK_W];
            end
        end
    end

    assign req_ready = ~full;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_req   = (state_q == S_ISSUE);
    assign mem_write = mem_req && ent_wr_q;
    assign mem_addr  = mem_req ? ent_addr_q : '0;
    assign mem_wdata = mem_req ? ent_data_q : '0;
    assign mem_mask  = !mem_req ? '0 : (ent_wr_q ? ent_mask_q : {MASK_W{1'b1}});
    assign dbg_state = state_q;

endmodule
